// File: rtl/control_velocidad_enemigos_pkg.sv
// Shared types and defaults for the enemy speed controller.
// Holds the game-state encoding, default timing constants and period helper.
package control_velocidad_enemigos_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSA = 2'b10,
      FIN   = 2'b11
   } estado_t;

   localparam logic [26:0] PERIODO_BASE_DEF    = 27'd222222;
   localparam logic [26:0] PASO_PERIODO_DEF    = 27'd20000;
   localparam logic [26:0] PERIODO_MIN_DEF     = 27'd60000;
   localparam logic [7:0]  TICKS_POR_NIVEL_DEF = 8'd64;
   localparam logic [2:0]  NIVEL_MAX_DEF       = 3'd7;

   // Period for a level, floored at minimo. The comparison is done before
   // the subtraction so the 27-bit result can never wrap below zero.
   function automatic logic [26:0] calc_periodo(
      input logic [2:0]  nivel,
      input logic [26:0] base,
      input logic [26:0] paso,
      input logic [26:0] minimo
   );
      logic [26:0] reduccion;
      reduccion = 27'(nivel) * paso;
      if (reduccion >= base - minimo)
         return minimo;
      else
         return base - reduccion;
   endfunction

endpackage

// File: rtl/control_velocidad_enemigos_divisor.sv
// Programmable 27-bit divider: counts 0..periodo-1 while enabled and
// flags the wrap; also drives y, high for the first half of the period.
// Ports: clock_in, reset (sync, high), en (count), carga (restart at z=0
// with periodo_nuevo), apaga_y (force y low), periodo_nuevo (value loaded
// on carga or wrap), wrap (z at last count), y (half-period square wave).
module divisor_programable #(
   parameter logic [26:0] PERIODO_RESET = 27'd222222
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        en,
   input  logic        carga,
   input  logic        apaga_y,
   input  logic [26:0] periodo_nuevo,
   output logic        wrap,
   output logic        y
);

   logic [26:0] z_q, z_d;
   logic [26:0] periodo_q, periodo_d;
   logic        y_q, y_d;

   assign wrap = (z_q == periodo_q - 27'd1);
   assign y    = y_q;

   always_comb begin
      z_d       = z_q;
      periodo_d = periodo_q;
      y_d       = y_q;
      if (carga) begin
         z_d       = '0;
         periodo_d = periodo_nuevo;
      end else if (en) begin
         y_d = (z_q < (periodo_q >> 1));
         // The period is only swapped at a wrap, never mid-count.
         if (wrap) begin
            z_d       = '0;
            periodo_d = periodo_nuevo;
         end else begin
            z_d = z_q + 27'd1;
         end
      end
      if (apaga_y)
         y_d = 1'b0;
   end

   always_ff @(negedge clock_in) begin
      if (reset) begin
         z_q       <= '0;
         periodo_q <= PERIODO_RESET;
         y_q       <= 1'b0;
      end else begin
         z_q       <= z_d;
         periodo_q <= periodo_d;
         y_q       <= y_d;
      end
   end

endmodule

// File: rtl/control_velocidad_enemigos.sv
// Enemy speed controller: game FSM, level/period schedule and round-robin
// distribution of one shared divider tick over NUM_ENEMIGOS lanes.
// Ports: clock_in (all logic on negedge), reset (sync, high), iniciar,
// pausa, choque in; tick_en (one-hot lane enable), y, nivel, estado,
// jugando out.
module control_velocidad_enemigos
   import control_velocidad_enemigos_pkg::*;
#(
   parameter logic [26:0] PERIODO_BASE    = PERIODO_BASE_DEF,
   parameter logic [26:0] PASO_PERIODO    = PASO_PERIODO_DEF,
   parameter logic [26:0] PERIODO_MIN     = PERIODO_MIN_DEF,
   parameter logic [7:0]  TICKS_POR_NIVEL = TICKS_POR_NIVEL_DEF,
   parameter logic [2:0]  NIVEL_MAX       = NIVEL_MAX_DEF,
   parameter int          NUM_ENEMIGOS    = 6
) (
   input  logic                    clock_in,
   input  logic                    reset,
   input  logic                    iniciar,
   input  logic                    pausa,
   input  logic                    choque,
   output logic [NUM_ENEMIGOS-1:0] tick_en,
   output logic                    y,
   output logic [2:0]              nivel,
   output logic [1:0]              estado,
   output logic                    jugando
);

   localparam int IW = (NUM_ENEMIGOS > 1) ? $clog2(NUM_ENEMIGOS) : 1;

   estado_t                 estado_q, estado_d;
   logic [2:0]              nivel_q, nivel_d;
   logic [7:0]              cuenta_q, cuenta_d;
   logic [IW-1:0]           indice_q, indice_d;
   logic [NUM_ENEMIGOS-1:0] tick_q, tick_d;
   logic                    jugando_q, jugando_d;

   logic        avanza;
   logic        carga;
   logic        apaga_y;
   logic        wrap;
   logic [26:0] periodo_nuevo;

   // Both a fresh start (nivel_d = 0) and a wrap load the period of the
   // level that will be current after this edge.
   assign periodo_nuevo = calc_periodo(nivel_d, PERIODO_BASE,
                                       PASO_PERIODO, PERIODO_MIN);

   always_comb begin
      estado_d = estado_q;
      nivel_d  = nivel_q;
      cuenta_d = cuenta_q;
      indice_d = indice_q;
      tick_d   = '0;
      avanza   = 1'b0;
      carga    = 1'b0;
      apaga_y  = 1'b0;
      unique case (estado_q)
         IDLE, FIN: begin
            apaga_y = 1'b1;
            if (iniciar) begin
               estado_d = RUN;
               carga    = 1'b1;
               nivel_d  = '0;
               cuenta_d = '0;
               indice_d = '0;
            end
         end
         RUN: begin
            if (choque) begin
               estado_d = FIN;
               apaga_y  = 1'b1;
            end else if (pausa) begin
               estado_d = PAUSA;
            end else begin
               avanza = 1'b1;
            end
         end
         PAUSA: begin
            if (choque) begin
               estado_d = FIN;
               apaga_y  = 1'b1;
            end else if (!pausa) begin
               // The release edge already counts, so z is frozen for
               // exactly the edges on which pausa was high.
               estado_d = RUN;
               avanza   = 1'b1;
            end
         end
      endcase
      if (avanza && wrap) begin
         tick_d = NUM_ENEMIGOS'(1) << indice_q;
         if (indice_q == IW'(NUM_ENEMIGOS - 1))
            indice_d = '0;
         else
            indice_d = indice_q + IW'(1);
         if (cuenta_q == TICKS_POR_NIVEL - 8'd1) begin
            cuenta_d = '0;
            if (nivel_q != NIVEL_MAX)
               nivel_d = nivel_q + 3'd1;
         end else begin
            cuenta_d = cuenta_q + 8'd1;
         end
      end
      jugando_d = (estado_d == RUN);
   end

   always_ff @(negedge clock_in) begin
      if (reset) begin
         estado_q  <= IDLE;
         nivel_q   <= '0;
         cuenta_q  <= '0;
         indice_q  <= '0;
         tick_q    <= '0;
         jugando_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         nivel_q   <= nivel_d;
         cuenta_q  <= cuenta_d;
         indice_q  <= indice_d;
         tick_q    <= tick_d;
         jugando_q <= jugando_d;
      end
   end

   divisor_programable #(
      .PERIODO_RESET(PERIODO_BASE)
   ) u_divisor (
      .clock_in     (clock_in),
      .reset        (reset),
      .en           (avanza),
      .carga        (carga),
      .apaga_y      (apaga_y),
      .periodo_nuevo(periodo_nuevo),
      .wrap         (wrap),
      .y            (y)
   );

   assign tick_en = tick_q;
   assign nivel   = nivel_q;
   assign estado  = estado_q;
   assign jugando = jugando_q;

endmodule
